// File: rtl/mldsa_params_pkg.sv
// Shared ML-DSA memory parameters, command encoding and memory arbiter state types.
package mldsa_params_pkg;

  localparam int unsigned MEM_DATA_WIDTH       = 24;
  localparam int unsigned MLDSA_MEM_ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    RW_IDLE  = 2'd0,
    RW_READ  = 2'd1,
    RW_WRITE = 2'd2
  } rw_e;

  typedef struct packed {
    rw_e                             rd_wr_en;
    logic [MLDSA_MEM_ADDR_WIDTH-1:0] addr;
  } mem_if_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWN_A = 2'd1,
    ARB_OWN_B = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_e;

  localparam mem_if_t MEM_IF_IDLE = '{rd_wr_en: RW_IDLE, addr: '0};

endpackage

// File: rtl/mldsa_mem_rd_tag.sv
// One-cycle read-return tag for a single memory port: remembers who issued the
// read so the data is steered back to that requester even if the grant has moved.
module mldsa_mem_rd_tag
  import mldsa_params_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      issue,
  input  owner_e                    issuer,
  input  logic [MEM_DATA_WIDTH-1:0] read_data,
  output logic                      a_rvalid,
  output logic [MEM_DATA_WIDTH-1:0] a_rdata,
  output logic                      b_rvalid,
  output logic [MEM_DATA_WIDTH-1:0] b_rdata
);

  logic   tag_valid;
  owner_e tag_owner;

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_valid <= 1'b0;
      tag_owner <= OWNER_A;
    end else begin
      tag_valid <= issue;
      tag_owner <= issuer;
    end
  end

  assign a_rvalid = tag_valid && (tag_owner == OWNER_A);
  assign b_rvalid = tag_valid && (tag_owner == OWNER_B);
  assign a_rdata  = a_rvalid ? read_data : '0;
  assign b_rdata  = b_rvalid ? read_data : '0;

endmodule

// File: rtl/mldsa_mem_arbiter.sv
// Two-requester (NTT / sampler) arbiter for a dual-port ML-DSA memory with
// alternating tie-break, bounded hold time, owner lock and tagged read return.
module mldsa_mem_arbiter
  import mldsa_params_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      a_req,
  input  logic                      b_req,
  input  logic                      a_lock,
  input  logic                      b_lock,
  output logic                      a_gnt,
  output logic                      b_gnt,
  input  mem_if_t                   a_port0_req,
  input  mem_if_t                   a_port1_req,
  input  mem_if_t                   b_port0_req,
  input  mem_if_t                   b_port1_req,
  input  logic [MEM_DATA_WIDTH-1:0] a_p0_wdata,
  input  logic [MEM_DATA_WIDTH-1:0] a_p1_wdata,
  input  logic [MEM_DATA_WIDTH-1:0] b_p0_wdata,
  input  logic [MEM_DATA_WIDTH-1:0] b_p1_wdata,
  output logic [MEM_DATA_WIDTH-1:0] a_p0_rdata,
  output logic [MEM_DATA_WIDTH-1:0] a_p1_rdata,
  output logic [MEM_DATA_WIDTH-1:0] b_p0_rdata,
  output logic [MEM_DATA_WIDTH-1:0] b_p1_rdata,
  output logic                      a_p0_rvalid,
  output logic                      a_p1_rvalid,
  output logic                      b_p0_rvalid,
  output logic                      b_p1_rvalid,
  output mem_if_t                   mem_port0_req,
  output mem_if_t                   mem_port1_req,
  output logic [MEM_DATA_WIDTH-1:0] p0_write_data,
  output logic [MEM_DATA_WIDTH-1:0] p1_write_data,
  input  logic [MEM_DATA_WIDTH-1:0] p0_read_data,
  input  logic [MEM_DATA_WIDTH-1:0] p1_read_data
);

  localparam int unsigned     CNT_W     = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  arb_state_e       state;
  arb_state_e       state_next;
  owner_e           last_owner;
  logic [CNT_W-1:0] hold_cnt;
  logic             hold_done;
  logic             issue0;
  logic             issue1;
  owner_e           issuer;

  assign hold_done = (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= ARB_IDLE;
    else       state <= state_next;
  end

  // Ownership decision: release hands over directly, expiry preempts unless locked.
  always_comb begin
    state_next = state;
    unique case (state)
      ARB_IDLE: begin
        if (a_req && b_req) state_next = (last_owner == OWNER_A) ? ARB_OWN_B : ARB_OWN_A;
        else if (a_req)     state_next = ARB_OWN_A;
        else if (b_req)     state_next = ARB_OWN_B;
      end
      ARB_OWN_A: begin
        if (!a_req)                            state_next = b_req ? ARB_OWN_B : ARB_IDLE;
        else if (b_req && !a_lock && hold_done) state_next = ARB_OWN_B;
      end
      ARB_OWN_B: begin
        if (!b_req)                            state_next = a_req ? ARB_OWN_A : ARB_IDLE;
        else if (a_req && !b_lock && hold_done) state_next = ARB_OWN_A;
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  // Grants, tie-break history and tenure counter follow the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_gnt      <= 1'b0;
      b_gnt      <= 1'b0;
      last_owner <= OWNER_B;
      hold_cnt   <= '0;
    end else begin
      a_gnt <= (state_next == ARB_OWN_A);
      b_gnt <= (state_next == ARB_OWN_B);
      if (state_next == ARB_OWN_A)      last_owner <= OWNER_A;
      else if (state_next == ARB_OWN_B) last_owner <= OWNER_B;
      if ((state_next != state) || (state_next == ARB_IDLE)) hold_cnt <= '0;
      else if (!hold_done)                                    hold_cnt <= hold_cnt + CNT_W'(1);
    end
  end

  // Owner's commands pass straight through; everything else is dropped.
  always_comb begin
    mem_port0_req = MEM_IF_IDLE;
    mem_port1_req = MEM_IF_IDLE;
    p0_write_data = '0;
    p1_write_data = '0;
    case (state)
      ARB_OWN_A: begin
        mem_port0_req = a_port0_req;
        mem_port1_req = a_port1_req;
        p0_write_data = a_p0_wdata;
        p1_write_data = a_p1_wdata;
      end
      ARB_OWN_B: begin
        mem_port0_req = b_port0_req;
        mem_port1_req = b_port1_req;
        p0_write_data = b_p0_wdata;
        p1_write_data = b_p1_wdata;
      end
      default: ;
    endcase
  end

  assign issue0 = (mem_port0_req.rd_wr_en == RW_READ);
  assign issue1 = (mem_port1_req.rd_wr_en == RW_READ);
  assign issuer = (state == ARB_OWN_B) ? OWNER_B : OWNER_A;

  mldsa_mem_rd_tag u_rd_tag_p0 (
    .clk       (clk),
    .reset     (reset),
    .issue     (issue0),
    .issuer    (issuer),
    .read_data (p0_read_data),
    .a_rvalid  (a_p0_rvalid),
    .a_rdata   (a_p0_rdata),
    .b_rvalid  (b_p0_rvalid),
    .b_rdata   (b_p0_rdata)
  );

  mldsa_mem_rd_tag u_rd_tag_p1 (
    .clk       (clk),
    .reset     (reset),
    .issue     (issue1),
    .issuer    (issuer),
    .read_data (p1_read_data),
    .a_rvalid  (a_p1_rvalid),
    .a_rdata   (a_p1_rdata),
    .b_rvalid  (b_p1_rvalid),
    .b_rdata   (b_p1_rdata)
  );

endmodule

// File: tb/tb_mldsa_mem_arbiter.sv
// Bench for mldsa_mem_arbiter: directed scenarios plus randomized traffic checked
// against a tenure/run-length reference model and a shadow memory.
module tb_mldsa_mem_arbiter;
  import mldsa_params_pkg::*;

  localparam int unsigned HOLD  = 16;
  localparam int unsigned DW    = MEM_DATA_WIDTH;
  localparam int unsigned AW    = MLDSA_MEM_ADDR_WIDTH;
  localparam int unsigned DEPTH = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, a_req, b_req, a_lock, b_lock, a_gnt, b_gnt;
  mem_if_t a_port0_req, a_port1_req, b_port0_req, b_port1_req, mem_port0_req, mem_port1_req;
  logic [DW-1:0] a_p0_wdata, a_p1_wdata, b_p0_wdata, b_p1_wdata;
  logic [DW-1:0] a_p0_rdata, a_p1_rdata, b_p0_rdata, b_p1_rdata;
  logic a_p0_rvalid, a_p1_rvalid, b_p0_rvalid, b_p1_rvalid;
  logic [DW-1:0] p0_write_data, p1_write_data, p0_read_data, p1_read_data;

  mldsa_mem_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk(clk), .reset(reset), .a_req(a_req), .b_req(b_req), .a_lock(a_lock), .b_lock(b_lock),
    .a_gnt(a_gnt), .b_gnt(b_gnt),
    .a_port0_req(a_port0_req), .a_port1_req(a_port1_req),
    .b_port0_req(b_port0_req), .b_port1_req(b_port1_req),
    .a_p0_wdata(a_p0_wdata), .a_p1_wdata(a_p1_wdata), .b_p0_wdata(b_p0_wdata), .b_p1_wdata(b_p1_wdata),
    .a_p0_rdata(a_p0_rdata), .a_p1_rdata(a_p1_rdata), .b_p0_rdata(b_p0_rdata), .b_p1_rdata(b_p1_rdata),
    .a_p0_rvalid(a_p0_rvalid), .a_p1_rvalid(a_p1_rvalid), .b_p0_rvalid(b_p0_rvalid), .b_p1_rvalid(b_p1_rvalid),
    .mem_port0_req(mem_port0_req), .mem_port1_req(mem_port1_req),
    .p0_write_data(p0_write_data), .p1_write_data(p1_write_data),
    .p0_read_data(p0_read_data), .p1_read_data(p1_read_data)
  );

  int checks = 0;
  int failures = 0;

  function automatic logic [DW-1:0] seed_val(int unsigned i);
    return DW'(i * 32'd40503 + 32'd12345);
  endfunction

  // Memory behind the arbiter: one-cycle read latency on both ports.
  logic mem_load;
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= seed_val(i);
    end else begin
      if (mem_port0_req.rd_wr_en == RW_WRITE) mem[mem_port0_req.addr] <= p0_write_data;
      if (mem_port1_req.rd_wr_en == RW_WRITE) mem[mem_port1_req.addr] <= p1_write_data;
    end
    p0_read_data <= (mem_port0_req.rd_wr_en == RW_READ) ? mem[mem_port0_req.addr] : '0;
    p1_read_data <= (mem_port1_req.rd_wr_en == RW_READ) ? mem[mem_port1_req.addr] : '0;
  end

  // Reference model: owner 0=none 1=A 2=B, run = cycles granted in current tenure.
  int m_owner, m_last, m_run;
  bit pv [2];
  int pwho [2];
  logic [DW-1:0] pdata [2];
  logic [DW-1:0] ref_mem [DEPTH];

  function automatic mem_if_t own_req(int own, int p);
    if (own == 1) return (p == 0) ? a_port0_req : a_port1_req;
    if (own == 2) return (p == 0) ? b_port0_req : b_port1_req;
    return '0;
  endfunction

  function automatic logic [DW-1:0] own_wdata(int own, int p);
    if (own == 1) return (p == 0) ? a_p0_wdata : a_p1_wdata;
    if (own == 2) return (p == 0) ? b_p0_wdata : b_p1_wdata;
    return '0;
  endfunction

  task automatic advance();
    mem_if_t r;
    int nxt, other;
    bit want_own, want_oth, lock_own, rst_now;
    bit npv [2];
    int npw [2];
    logic [DW-1:0] npd [2];
    rst_now = reset;
    for (int p = 0; p < 2; p++) begin
      r = own_req(m_owner, p);
      npv[p] = (m_owner != 0) && (r.rd_wr_en == RW_READ);
      npw[p] = m_owner;
      npd[p] = ref_mem[r.addr];
    end
    for (int p = 0; p < 2; p++) begin
      r = own_req(m_owner, p);
      if (m_owner != 0 && r.rd_wr_en == RW_WRITE) ref_mem[r.addr] = own_wdata(m_owner, p);
    end
    if (m_owner == 0) begin
      if (a_req && b_req) nxt = (m_last == 1) ? 2 : 1;
      else if (a_req)     nxt = 1;
      else if (b_req)     nxt = 2;
      else                nxt = 0;
    end else begin
      other    = 3 - m_owner;
      want_own = (m_owner == 1) ? a_req : b_req;
      want_oth = (m_owner == 1) ? b_req : a_req;
      lock_own = (m_owner == 1) ? a_lock : b_lock;
      if (!want_own)                                    nxt = want_oth ? other : 0;
      else if (want_oth && !lock_own && m_run >= int'(HOLD)) nxt = other;
      else                                              nxt = m_owner;
    end
    @(posedge clk); #1;
    if (rst_now) begin
      m_owner = 0; m_last = 2; m_run = 0; pv[0] = 0; pv[1] = 0;
    end else begin
      m_run = (nxt != 0 && nxt == m_owner) ? m_run + 1 : ((nxt != 0) ? 1 : 0);
      if (nxt != 0) m_last = nxt;
      m_owner = nxt;
      pv = npv; pwho = npw; pdata = npd;
    end
  endtask

  task automatic clear_inputs();
    a_req = 0; b_req = 0; a_lock = 0; b_lock = 0;
    a_port0_req = '0; a_port1_req = '0; b_port0_req = '0; b_port1_req = '0;
    a_p0_wdata = '0; a_p1_wdata = '0; b_p0_wdata = '0; b_p1_wdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    advance();
    advance();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (a_gnt !== 1'b0 || b_gnt !== 1'b0) begin failures++; $display("FAIL reset_gnt got a=%b b=%b exp 0 0", a_gnt, b_gnt); end
    checks++; if ({a_p0_rvalid, a_p1_rvalid, b_p0_rvalid, b_p1_rvalid} !== 4'b0) begin failures++; $display("FAIL reset_rvalid got %b%b%b%b exp 0000", a_p0_rvalid, a_p1_rvalid, b_p0_rvalid, b_p1_rvalid); end
    checks++; if ((a_p0_rdata | a_p1_rdata | b_p0_rdata | b_p1_rdata) !== '0) begin failures++; $display("FAIL reset_rdata got nonzero exp 0"); end
    checks++; if (mem_port0_req !== '0 || mem_port1_req !== '0) begin failures++; $display("FAIL reset_memreq got %h %h exp 0 0", mem_port0_req, mem_port1_req); end
    checks++; if (p0_write_data !== '0 || p1_write_data !== '0) begin failures++; $display("FAIL reset_wdata got %h %h exp 0 0", p0_write_data, p1_write_data); end
  endtask

  task automatic test_single_grant();
    a_req = 1;
    advance();
    checks++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin failures++; $display("FAIL single_gnt got a=%b b=%b exp 1 0", a_gnt, b_gnt); end
    a_port0_req = '{rd_wr_en: RW_READ, addr: AW'(5)};
    a_port1_req = '{rd_wr_en: RW_READ, addr: AW'(200)};
    #1;
    checks++; if (mem_port0_req.rd_wr_en !== RW_READ || mem_port0_req.addr !== AW'(5)) begin failures++; $display("FAIL single_passthru got %h exp read@5", mem_port0_req); end
    advance();
    a_port0_req = '0; a_port1_req = '0;
    checks++; if (a_p0_rvalid !== 1'b1 || a_p0_rdata !== seed_val(5)) begin failures++; $display("FAIL single_rd_p0 got v=%b d=%h exp 1 %h", a_p0_rvalid, a_p0_rdata, seed_val(5)); end
    checks++; if (a_p1_rvalid !== 1'b1 || a_p1_rdata !== seed_val(200)) begin failures++; $display("FAIL single_rd_p1 got v=%b d=%h exp 1 %h", a_p1_rvalid, a_p1_rdata, seed_val(200)); end
    checks++; if (b_p0_rvalid !== 1'b0 || b_p0_rdata !== '0) begin failures++; $display("FAIL single_rd_b got v=%b d=%h exp 0 0", b_p0_rvalid, b_p0_rdata); end
    a_req = 0;
    advance();
    checks++; if (a_gnt !== 1'b0) begin failures++; $display("FAIL single_release got %b exp 0", a_gnt); end
  endtask

  task automatic test_tie();
    do_reset();
    a_req = 1; b_req = 1;
    advance();
    checks++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin failures++; $display("FAIL tie_first got a=%b b=%b exp 1 0", a_gnt, b_gnt); end
    a_req = 0;
    advance();
    checks++; if (a_gnt !== 1'b0 || b_gnt !== 1'b1) begin failures++; $display("FAIL tie_handover got a=%b b=%b exp 0 1", a_gnt, b_gnt); end
    b_req = 0;
    advance();
    checks++; if (b_gnt !== 1'b0) begin failures++; $display("FAIL tie_idle got %b exp 0", b_gnt); end
    a_req = 1; b_req = 1;
    advance();
    checks++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin failures++; $display("FAIL tie_second got a=%b b=%b exp 1 0", a_gnt, b_gnt); end
    a_req = 0; b_req = 0;
    advance();
  endtask

  task automatic test_hold_preempt();
    int cnt;
    a_req = 1;
    advance();
    b_req = 1;
    cnt = 1;
    for (int i = 0; i < 40; i++) begin
      advance();
      if (a_gnt) cnt++; else break;
    end
    checks++; if (cnt != int'(HOLD)) begin failures++; $display("FAIL hold_count got %0d exp %0d", cnt, HOLD); end
    checks++; if (b_gnt !== 1'b1) begin failures++; $display("FAIL hold_switch got %b exp 1", b_gnt); end
    a_req = 0; b_req = 0;
    advance();
  endtask

  task automatic test_lock();
    int cnt;
    a_req = 1; a_lock = 1;
    advance();
    b_req = 1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      advance();
      if (a_gnt) cnt++;
    end
    checks++; if (cnt != 40) begin failures++; $display("FAIL lock_hold got %0d exp 40", cnt); end
    a_req = 0; a_lock = 0;
    advance();
    checks++; if (a_gnt !== 1'b0 || b_gnt !== 1'b1) begin failures++; $display("FAIL lock_release got a=%b b=%b exp 0 1", a_gnt, b_gnt); end
    b_req = 0;
    advance();
  endtask

  task automatic test_read_at_switch();
    a_req = 1;
    advance();
    b_req = 1;
    repeat (HOLD - 1) advance();
    checks++; if (a_gnt !== 1'b1) begin failures++; $display("FAIL switch_last got %b exp 1", a_gnt); end
    a_port0_req = '{rd_wr_en: RW_READ, addr: AW'(9)};
    advance();
    a_port0_req = '0;
    checks++; if (b_gnt !== 1'b1) begin failures++; $display("FAIL switch_gnt got %b exp 1", b_gnt); end
    checks++; if (a_p0_rvalid !== 1'b1 || a_p0_rdata !== seed_val(9)) begin failures++; $display("FAIL switch_rd got v=%b d=%h exp 1 %h", a_p0_rvalid, a_p0_rdata, seed_val(9)); end
    checks++; if (b_p0_rvalid !== 1'b0 || b_p0_rdata !== '0) begin failures++; $display("FAIL switch_rd_b got v=%b d=%h exp 0 0", b_p0_rvalid, b_p0_rdata); end
    a_req = 0; b_req = 0;
    advance();
  endtask

  task automatic test_no_grant_write();
    b_port0_req = '{rd_wr_en: RW_WRITE, addr: AW'(3)};
    b_p0_wdata = DW'($urandom);
    #1;
    checks++; if (mem_port0_req.rd_wr_en !== RW_IDLE || p0_write_data !== '0) begin failures++; $display("FAIL nogrant_cmd got %h/%h exp idle/0", mem_port0_req, p0_write_data); end
    advance();
    b_port0_req = '0; b_p0_wdata = '0;
    a_req = 1;
    advance();
    a_port0_req = '{rd_wr_en: RW_READ, addr: AW'(3)};
    advance();
    a_port0_req = '0;
    checks++; if (a_p0_rdata !== seed_val(3)) begin failures++; $display("FAIL nogrant_mem got %h exp %h", a_p0_rdata, seed_val(3)); end
  endtask

  task automatic test_reset_in_flight();
    a_req = 1;
    advance();
    a_port0_req = '{rd_wr_en: RW_READ, addr: AW'(7)};
    reset = 1;
    advance();
    a_port0_req = '0;
    reset = 0;
    checks++; if (a_p0_rvalid !== 1'b0 || a_gnt !== 1'b0) begin failures++; $display("FAIL rst_flight got v=%b g=%b exp 0 0", a_p0_rvalid, a_gnt); end
    advance();
    checks++; if (a_p0_rvalid !== 1'b0 || b_p0_rvalid !== 1'b0) begin failures++; $display("FAIL rst_flight_after got a=%b b=%b exp 0 0", a_p0_rvalid, b_p0_rvalid); end
    a_req = 0;
    advance();
  endtask

  task automatic test_random();
    mem_if_t e_req [2];
    mem_if_t act_req [2];
    logic [DW-1:0] e_wd [2];
    logic [DW-1:0] act_wd [2];
    logic act_v [4];
    logic [DW-1:0] act_d [4];
    logic e_v;
    logic [DW-1:0] e_d;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 7) == 0) a_req = ~a_req;
      if ($urandom_range(0, 7) == 0) b_req = ~b_req;
      if ($urandom_range(0, 29) == 0) a_lock = ~a_lock;
      if ($urandom_range(0, 29) == 0) b_lock = ~b_lock;
      a_port0_req = '{rd_wr_en: rw_e'($urandom_range(0, 2)), addr: AW'($urandom_range(0, 127))};
      b_port0_req = '{rd_wr_en: rw_e'($urandom_range(0, 2)), addr: AW'($urandom_range(0, 127))};
      a_port1_req = '{rd_wr_en: rw_e'($urandom_range(0, 2)), addr: AW'($urandom_range(128, 255))};
      b_port1_req = '{rd_wr_en: rw_e'($urandom_range(0, 2)), addr: AW'($urandom_range(128, 255))};
      a_p0_wdata = DW'($urandom); a_p1_wdata = DW'($urandom);
      b_p0_wdata = DW'($urandom); b_p1_wdata = DW'($urandom);
      reset = ($urandom_range(0, 249) == 0);
      #1;
      act_req[0] = mem_port0_req; act_req[1] = mem_port1_req;
      act_wd[0] = p0_write_data;  act_wd[1] = p1_write_data;
      for (int p = 0; p < 2; p++) begin
        e_req[p] = own_req(m_owner, p);
        e_wd[p]  = own_wdata(m_owner, p);
        checks++;
        if (act_req[p] !== e_req[p] || act_wd[p] !== e_wd[p]) begin
          failures++;
          $display("FAIL rand_cmd cyc=%0d port=%0d got %h/%h exp %h/%h", cyc, p, act_req[p], act_wd[p], e_req[p], e_wd[p]);
        end
      end
      advance();
      checks++;
      if (a_gnt !== (m_owner == 1) || b_gnt !== (m_owner == 2)) begin
        failures++;
        $display("FAIL rand_gnt cyc=%0d got a=%b b=%b exp owner=%0d", cyc, a_gnt, b_gnt, m_owner);
      end
      act_v[0] = a_p0_rvalid; act_v[1] = a_p1_rvalid; act_v[2] = b_p0_rvalid; act_v[3] = b_p1_rvalid;
      act_d[0] = a_p0_rdata;  act_d[1] = a_p1_rdata;  act_d[2] = b_p0_rdata;  act_d[3] = b_p1_rdata;
      for (int k = 0; k < 4; k++) begin
        e_v = pv[k % 2] && (pwho[k % 2] == (k / 2) + 1);
        e_d = e_v ? pdata[k % 2] : '0;
        checks++;
        if (act_v[k] !== e_v || act_d[k] !== e_d) begin
          failures++;
          $display("FAIL rand_rd cyc=%0d slot=%0d got v=%b d=%h exp v=%b d=%h", cyc, k, act_v[k], act_d[k], e_v, e_d);
        end
      end
    end
    reset = 0;
    clear_inputs();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    m_owner = 0; m_last = 2; m_run = 0;
    pv[0] = 0; pv[1] = 0; pwho[0] = 0; pwho[1] = 0; pdata[0] = '0; pdata[1] = '0;
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = seed_val(i);
    reset = 1;
    clear_inputs();
    mem_load = 1;
    test_reset();
    mem_load = 0;
    test_single_grant();
    test_tie();
    test_hold_preempt();
    test_lock();
    test_read_at_switch();
    test_no_grant_write();
    test_reset_in_flight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mldsa_mem_arbiter.md
MLDSA_MEM_ARBITER -- requirements
Module: mldsa_mem_arbiter

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 16, maximum consecutive granted cycles for an unlocked owner while the other requester waits.
REQ-002 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports a_req / b_req  input  1  requester A (NTT) / B (sampler) wants the memory.
REQ-005 SHALL have ports a_lock / b_lock  input  1  owner forbids preemption while high.
REQ-006 SHALL have ports a_gnt / b_gnt  output  1  registered grant.
REQ-007 SHALL have ports a_port0_req, a_port1_req, b_port0_req, b_port1_req  input  mem_if_t  per-requester commands (rd_wr_en, addr).
REQ-008 SHALL have ports a_p0_wdata, a_p1_wdata, b_p0_wdata, b_p1_wdata  input  MEM_DATA_WIDTH  write data.
REQ-009 SHALL have ports a_p0_rdata, a_p1_rdata, b_p0_rdata, b_p1_rdata  output  MEM_DATA_WIDTH  returned read data.
REQ-010 SHALL have ports a_p0_rvalid, a_p1_rvalid, b_p0_rvalid, b_p1_rvalid  output  1  read data valid.
REQ-011 SHALL have ports mem_port0_req, mem_port1_req  output  mem_if_t; p0_write_data, p1_write_data  output  MEM_DATA_WIDTH; p0_read_data, p1_read_data  input  MEM_DATA_WIDTH  memory side.

Function
REQ-012 SHALL implement FSM IDLE, OWN_A, OWN_B; a_gnt=1 only in OWN_A, b_gnt=1 only in OWN_B.
REQ-013 IDLE: sole requester -> its OWN state next cycle; both requesting -> requester not in last_owner; none -> stay IDLE.
REQ-014 OWN_x: owner drops req -> if other requests go to OTHER OWN directly, else IDLE.
REQ-015 OWN_x: owner req high, lock low, other requesting, hold_cnt==HOLD_MAX-1 -> OWN of other (preemption), no bubble cycle.
REQ-016 hold_cnt SHALL reset to 0 on every ownership change or entry to IDLE, increment each OWN cycle, saturate at HOLD_MAX-1; lock high freezes preemption but not counting.
REQ-017 last_owner SHALL update on every entry to OWN_A/OWN_B.
REQ-018 Memory commands SHALL be combinational pass-through of the current owner's port requests and write data; in IDLE rd_wr_en=RW_IDLE, addr=0, write data=0.
REQ-019 A command SHALL be honoured only in a cycle where that requester's gnt is high; commands presented without grant are dropped.
REQ-020 Read latency 1 cycle: per port, a registered tag (issuer, valid) captured when owner issues RW_READ; next cycle issuer's rvalid=1, rdata=pX_read_data; non-issuer rdata=0, rvalid=0.
REQ-021 A read issued on the last cycle before an ownership change SHALL return to its issuer even though grant has moved.
REQ-022 Port 0 and port 1 tags SHALL be independent; both ports may read in the same cycle.

Reset
REQ-023 On reset: state IDLE, gnts 0, hold_cnt 0, last_owner=B (A wins first tie), read tags cleared, all rvalid/rdata 0, memory requests RW_IDLE/addr 0.
REQ-024 Reset mid-operation SHALL drop any outstanding read tag; no rvalid in the cycle after reset.

Structure
REQ-025 mem_if_t, rd_wr_en encoding, MEM_DATA_WIDTH, MLDSA_MEM_ADDR_WIDTH SHALL come from mldsa_params_pkg; arbiter FSM state enum SHALL be added to the same package.
REQ-026 Per-port read-return tag logic SHALL be one sub-module mldsa_mem_rd_tag, instantiated twice.

Verification
REQ-027 Reset, then a_req=1 only -> a_gnt=1 one cycle later; A read addr 5 -> a_p0_rvalid next cycle with mem[5].
REQ-028 a_req and b_req rise together after reset -> A granted; A releases -> b_gnt same edge a_gnt falls; next tie -> B loses? no: last_owner=B -> A wins again.
REQ-029 A holds req, lock=0, B waiting, HOLD_MAX=16 -> a_gnt high exactly 16 cycles, then b_gnt.
REQ-030 Same as 029 with a_lock=1 -> no preemption until a_req drops.
REQ-031 A reads addr 9 on final granted cycle before switch to B -> a_p0_rvalid next cycle with mem[9]; b_p0_rvalid=0.
REQ-032 B drives RW_WRITE without grant -> mem_port0_req stays RW_IDLE, memory unchanged; reset asserted with read in flight -> no rvalid afterward.
